stack_alu_ctrl: RTL
===================

// Module: stack_alu_ctrl
// PURPOSE
//  Operand-issuing controller for the ALU: owns a DEPTH-entry operand stack, accepts push/op commands,
//  pops operands, drives ALU x/y/alpha, waits ALU_LAT cycles, captures z/segno and pushes the result.
//  Sits between the command source and the combinational ALU instance in the stack unit.
// PARAMETERS
//  N        32  operand/result width; must match the ALU N
//  DEPTH     8  stack entries (>=2)
//  ALU_LAT   2  cycles z is allowed to settle before capture (>=1); must cover the ALU's internal delay
// PORTS
//  clock      in   1      single clock, rising edge
//  reset      in   1      asynchronous, active-high
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      high only in IDLE; command accepted when valid&&ready at rising edge
//  cmd_push   in   1      1 = push cmd_data; 0 = ALU op cmd_alpha
//  cmd_alpha  in   3      op code as ALU: 0 add,1 sub,2 x+1,3 x-1,4 y+1,5 y-1,6 div; 7 illegal
//  cmd_data   in   N      push value
//  x, y       out  N      ALU operands (registered)
//  alpha      out  3      ALU op select (registered)
//  z          in   N      ALU result
//  segno      in   1      ALU sign flag (1 = non-negative, 0 = negative)
//  top        out  N      current top of stack (0 when empty)
//  count      out  $clog2(DEPTH+1)  entries in stack
//  res_segno  out  1      segno captured with last ALU result
//  err        out  3      0 ok,1 overflow,2 underflow,3 div-by-zero,4 illegal op; updated per command
//  done       out  1      one-cycle pulse when a command completes (ok or error)
// BEHAVIOUR
//  - Reset (async): state IDLE, stack/count cleared, x=y=0, alpha=0, top=0, res_segno=0, err=0, done=0.
//  - FSM IDLE -> WAIT -> WRITE -> IDLE. Only ALU ops with no error leave IDLE.
//  - Push (IDLE): count<DEPTH -> entry written, count+1, err=0; count==DEPTH -> no change, err=1.
//    done high the cycle after acceptance; cmd_ready stays high (back-to-back pushes allowed).
//  - Operand mapping: binary 0,1,6: y=top, x=next-below; result = x op y; pops 2 pushes 1.
//    ops 2,3: x=top, y=0; ops 4,5: y=top, x=0; pop 1 push 1.
//  - Errors checked at acceptance, stack untouched, done next cycle, stay IDLE:
//    binary with count<2 or unary with count<1 -> err=2; op6 with y operand==0 -> err=3 (checked
//    after underflow); alpha 7 -> err=4.
//  - Valid op: acceptance edge loads x/y/alpha, pops operands, state WAIT, wait counter=ALU_LAT-1.
//    WAIT decrements; at 0 -> WRITE. WRITE edge: push z, res_segno<=segno, err=0, done=1, -> IDLE.
//    Result visible on top exactly ALU_LAT+1 cycles after acceptance edge; next cmd_ready the cycle after.
//  - x/y/alpha hold their values after WRITE until the next valid op (no spurious ALU toggling).
//  - Arithmetic is modulo 2^N (done by the ALU); results never fail to push (net stack change <=0).
//  - cmd_* ignored when cmd_ready=0. done is low in all other cycles.
//  - Reset mid-operation: immediate return to reset state; the pending op is lost, no done pulse.
// TESTING
//  1 push 5, push 3, op 1 -> after ALU_LAT+1 cycles top=2, count=1, res_segno=1, err=0, one done pulse
//  2 push 3, push 5, op 1 -> top=32'hFFFFFFFE, res_segno=0; then op 2 -> top=32'hFFFFFFFF
//  3 push 9 DEPTH times then push 1 -> count=DEPTH, err=1, top=9; op 0 on empty stack -> err=2
//  4 push 7, push 0, op 6 -> err=3, count=2, top=0, no WAIT entry; alpha 7 -> err=4
//  5 push 20, push 6, op 6 -> top=3; cmd_valid held high during WAIT ignored (ready low, count stable)
//  6 assert reset during WAIT -> all outputs 0, count 0, cmd_ready high after release, no done pulse

Source files
------------

// File: rtl/stack_alu_ctrl.sv
// Operand-stack controller feeding a combinational ALU.
// Accepts push/op commands, issues x/y/alpha, waits ALU_LAT, pushes z.
//
// Ports:
//   clock, reset        rising-edge clock, async active-high reset
//   cmd_valid/ready     command handshake (ready only in IDLE)
//   cmd_push            1 = push cmd_data, 0 = ALU op cmd_alpha
//   cmd_alpha/cmd_data  op code / push value
//   x, y, alpha         registered ALU operands and op select
//   z, segno            ALU result and sign flag
//   top, count          top of stack (0 when empty), entry count
//   res_segno           segno captured with last result
//   err                 0 ok,1 ovf,2 udf,3 div0,4 illegal
//   done                one-cycle completion pulse
module stack_alu_ctrl #(
  parameter int N       = 32,
  parameter int DEPTH   = 8,
  parameter int ALU_LAT = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_push,
  input  logic [2:0]                 cmd_alpha,
  input  logic [N-1:0]               cmd_data,
  output logic [N-1:0]               x,
  output logic [N-1:0]               y,
  output logic [2:0]                 alpha,
  input  logic [N-1:0]               z,
  input  logic                       segno,
  output logic [N-1:0]               top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       res_segno,
  output logic [2:0]                 err,
  output logic                       done
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int WW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_WRITE
  } state_t;

  state_t         state;
  logic [WW-1:0]  wcnt;
  logic [N-1:0]   stk [DEPTH];
  logic [N-1:0]   topv;
  logic [N-1:0]   nxtv;
  logic           is_bin;
  logic           is_xu;
  logic           is_yu;
  logic [2:0]     operr;
  logic           we;
  logic [N-1:0]   wdat;
  logic           acc;

  assign acc = cmd_valid && cmd_ready;

  always_comb begin
    topv = '0;
    nxtv = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(count) == i + 1) topv = stk[i];
      if (int'(count) == i + 2) nxtv = stk[i];
    end
  end

  assign top = topv;

  always_comb begin
    is_bin = (cmd_alpha == 3'd0) ||
             (cmd_alpha == 3'd1) ||
             (cmd_alpha == 3'd6);
    is_xu  = (cmd_alpha == 3'd2) ||
             (cmd_alpha == 3'd3);
    is_yu  = (cmd_alpha == 3'd4) ||
             (cmd_alpha == 3'd5);
  end

  // Underflow outranks div-by-zero: y is only meaningful
  // once both operands exist.
  always_comb begin
    operr = 3'd0;
    if (cmd_alpha == 3'd7)
      operr = 3'd4;
    else if (is_bin && count < CW'(2))
      operr = 3'd2;
    else if (!is_bin && count == '0)
      operr = 3'd2;
    else if (cmd_alpha == 3'd6 && topv == '0)
      operr = 3'd3;
  end

  // Both write sources land at index count: a push in IDLE,
  // or the result after its operands were already popped.
  always_comb begin
    we   = 1'b0;
    wdat = cmd_data;
    if (state == S_WRITE) begin
      we   = 1'b1;
      wdat = z;
    end else if (state == S_IDLE && acc &&
                 cmd_push && count < CW'(DEPTH)) begin
      we   = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < DEPTH; i++)
        if (int'(count) == i) stk[i] <= wdat;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      wcnt      <= '0;
      count     <= '0;
      x         <= '0;
      y         <= '0;
      alpha     <= '0;
      res_segno <= 1'b0;
      err       <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (acc && cmd_push) begin
            done <= 1'b1;
            if (count < CW'(DEPTH)) begin
              count <= count + CW'(1);
              err   <= 3'd0;
            end else begin
              err   <= 3'd1;
            end
          end else if (acc && operr != 3'd0) begin
            done <= 1'b1;
            err  <= operr;
          end else if (acc) begin
            alpha     <= cmd_alpha;
            wcnt      <= WW'(ALU_LAT - 1);
            state     <= S_WAIT;
            cmd_ready <= 1'b0;
            unique case (1'b1)
              is_bin: begin
                x     <= nxtv;
                y     <= topv;
                count <= count - CW'(2);
              end
              is_xu: begin
                x     <= topv;
                y     <= '0;
                count <= count - CW'(1);
              end
              is_yu: begin
                x     <= '0;
                y     <= topv;
                count <= count - CW'(1);
              end
              default: ;
            endcase
          end
        end
        S_WAIT: begin
          if (wcnt == '0) state <= S_WRITE;
          else            wcnt  <= wcnt - WW'(1);
        end
        S_WRITE: begin
          count     <= count + CW'(1);
          res_segno <= segno;
          err       <= 3'd0;
          done      <= 1'b1;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
